btn_debounce: RTL
=================

Name: btn_debounce

Overview:
- Input-side counterpart to the tick-driven LED drivers: turns a raw, bouncing push-button into clean, clk-synchronous events.
- Contains an internal tick generator, a 2-FF synchroniser and a tick-sampled qualification FSM.
- Outputs a debounced level plus one-cycle press and release strobes, which downstream LED/toggle logic consumes.

Parameters:
- TICK_DIV, 100000: clk cycles per sample tick (100 MHz -> 1 kHz tick).
- STABLE_TICKS, 10: consecutive ticks the new level must hold before it is accepted (10 ms).
- LONG_TICKS, 1000: ticks in PRESSED before btn_long fires. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- btn_in  input  1  raw button, asynchronous to clk, active-high.
- btn_level  output  1  debounced button level.
- btn_press  output  1  one-clk strobe on accepted 0->1.
- btn_release  output  1  one-clk strobe on accepted 1->0.
- btn_long  output  1  one-clk strobe on long press (tied 0 when the feature is compiled out).
- tick  output  1  internal sample tick, exported for sharing.

Behaviour:
- Reset (rst=0, async): all outputs 0, synchroniser flops 0, tick and qualification counters 0, state IDLE.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one clk when the counter equals TICK_DIV-1.
  - Free-running; not restarted by button activity.
- Synchroniser: two flops; btn_s lags btn_in by 2 clk. The FSM uses only btn_s.
- FSM states:
  - IDLE: level 0, stable. btn_s=1 -> WAIT_PRESS, cnt<=0.
  - WAIT_PRESS:
    - btn_s=0 -> IDLE, cnt<=0, no strobe. Bounce check has priority over tick in the same cycle.
    - Else on tick: cnt==STABLE_TICKS-1 -> PRESSED, btn_level<=1, btn_press<=1 for one clk. Otherwise cnt++.
  - PRESSED:
    - btn_s=0 -> WAIT_RELEASE, cnt<=0.
    - The long-press counter advances on tick (feature only).
  - WAIT_RELEASE:
    - btn_s=1 -> PRESSED, cnt<=0, no strobe. The long counter is not reset.
    - Else on tick: cnt==STABLE_TICKS-1 -> IDLE, btn_level<=0, btn_release<=1 for one clk. Otherwise cnt++.
- Latency: strobe asserts between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV+1 clk after a clean edge on btn_in, depending on tick phase.
- Strobes and btn_level are registered.
- Press and release strobes are mutually exclusive. Never two strobes of the same kind without the opposite one in between.
- Widths:
  - Tick counter $clog2(TICK_DIV).
  - Qualification counter $clog2(STABLE_TICKS).
  - Long counter $clog2(LONG_TICKS+1).
  - Counters never wrap inside a qualification window.
- Reset mid-qualification: aborts immediately, no strobe. If btn_in is still 1 after reset release, the press is re-qualified from IDLE.

Optional Feature:
- Macro BTN_LONG_PRESS_EN.
- Defined:
  - A long counter clears on entry to PRESSED from WAIT_PRESS and counts ticks in PRESSED/WAIT_RELEASE.
  - At LONG_TICKS-1 it pulses btn_long for one clk, then saturates: one pulse per press, no auto-repeat.
  - It clears on entry to IDLE.
- Undefined: no long counter logic; btn_long driven constant 0.

Decomposition:
- Package btn_pkg holds:
  - state encoding (IDLE=2'd0, WAIT_PRESS=2'd1, PRESSED=2'd2, WAIT_RELEASE=2'd3)
  - default TICK_DIV/STABLE_TICKS/LONG_TICKS constants.
- Sub-module tick_gen (clk, rst, tick) holds the free-running divider. It is instantiated once and reusable by the LED blocks.

Test Plan:
All tests use TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8.
- Reset: hold rst=0 with btn_in=1 -> all outputs 0. Release rst -> btn_press within 2+12+1 clk, exactly once.
- Clean press: btn_in 0->1 held 40 clk -> btn_press one pulse 11-15 clk after the edge, btn_level=1 thereafter, btn_release never.
- Bounce: toggle btn_in every 5 clk for 60 clk, then hold 0 -> no strobes, btn_level stays 0.
- Release with glitch: from PRESSED, drop btn_in for 6 clk, back to 1, then 0 held -> no strobe for the glitch, one btn_release after the final drop, btn_level=0.
- Long press (macro defined): hold pressed 50 clk -> exactly one btn_long about 8 ticks after btn_press, no repeat. Macro undefined -> btn_long constant 0.
- Reset mid WAIT_PRESS: assert rst 6 clk after the press edge -> no btn_press, counters 0, state IDLE.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default timing constants and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned TICK_DIV_DEF     = 100000;
  localparam int unsigned STABLE_TICKS_DEF = 10;
  localparam int unsigned LONG_TICKS_DEF   = 1000;

  // Width of a counter holding 0..n-1, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider: one-clk tick every TICK_DIV cycles.
// Not restarted by any activity, so several blocks can share it.
module tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW   = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next counter value, wrapping at TICK_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Counter and registered tick, high exactly while the counter sits at LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchroniser plus a tick-sampled qualification
// FSM producing a clean level and one-clk press/release strobes.
// Optional long-press strobe is compiled in with `define BTN_LONG_PRESS_EN;
// without it btn_long is tied to 0.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic tick
);

  localparam int unsigned QW = cnt_w(STABLE_TICKS);
  localparam logic [QW-1:0] QLAST = QW'(STABLE_TICKS - 1);

  if ((TICK_DIV < 1) || (STABLE_TICKS < 1) || (LONG_TICKS < 1)) begin : g_bad_param
    $error("btn_debounce: TICK_DIV, STABLE_TICKS and LONG_TICKS must be >= 1");
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic btn_m;
  logic btn_s;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_in;
      btn_s <= btn_m;
    end
  end

  btn_state_e    state_q;
  btn_state_e    state_d;
  logic [QW-1:0] qual_q;
  logic [QW-1:0] qual_d;

  // State and qualification counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      qual_q  <= '0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
    end
  end

  // Next state: a bounce back to the old level beats a tick in the same cycle.
  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_PRESS;
          qual_d  = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          qual_d  = '0;
        end else if (tick) begin
          if (qual_q == QLAST) begin
            state_d = PRESSED;
            qual_d  = '0;
          end else begin
            qual_d = qual_q + QW'(1);
          end
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = WAIT_RELEASE;
          qual_d  = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
          qual_d  = '0;
        end else if (tick) begin
          if (qual_q == QLAST) begin
            state_d = IDLE;
            qual_d  = '0;
          end else begin
            qual_d = qual_q + QW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        qual_d  = '0;
      end
    endcase
  end

  logic level_c;
  logic press_c;
  logic release_c;

  // Output decode from the state transition about to be taken.
  always_comb begin
    level_c   = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    press_c   = (state_q == WAIT_PRESS) && (state_d == PRESSED);
    release_c = (state_q == WAIT_RELEASE) && (state_d == IDLE);
  end

  // Registered level and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_level   <= level_c;
      btn_press   <= press_c;
      btn_release <= release_c;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LLAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] LSAT  = LW'(LONG_TICKS);

  logic [LW-1:0] long_q;
  logic [LW-1:0] long_d;
  logic          long_c;

  // Long-press counter: cleared on a fresh press or in IDLE, saturates after one pulse.
  always_comb begin
    long_d = long_q;
    long_c = 1'b0;
    if ((state_d == IDLE) || press_c) begin
      long_d = '0;
    end else if (tick && ((state_q == PRESSED) || (state_q == WAIT_RELEASE))
                 && (long_q != LSAT)) begin
      long_c = (long_q == LLAST);
      long_d = long_q + LW'(1);
    end
  end

  // Long counter and registered long-press strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      long_q   <= '0;
      btn_long <= 1'b0;
    end else begin
      long_q   <= long_d;
      btn_long <= long_c;
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule
